// File: rtl/alimentatore_rete_totale_pkg.sv
// Shared widths and state encoding for the network front/back stage.
package alimentatore_rete_totale_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;
  localparam int RES_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    WH     = 3'd0,
    EH     = 3'd1,
    WL     = 3'd2,
    EL     = 3'd3,
    SETTLE = 3'd4,
    OUT    = 3'd5,
    EOUT   = 3'd6
  } star_t;

endpackage

// File: rtl/alimentatore_rete_totale_contatore_attesa.sv
// Settle counter: counts the cycles x7_x0 has been stable and flags the last one.
module contatore_attesa
  import alimentatore_rete_totale_pkg::*;
#(
  parameter int T_SETTLE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fine
);

  logic [CNT_W-1:0] cnt;

  // Up-counter, cleared when the byte is complete, advanced while settling.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fine = (cnt == CNT_W'(T_SETTLE - 1));

endmodule

// File: rtl/alimentatore_rete_totale.sv
// Front/back stage around the 8-in/4-out network: nibble collection,
// settle wait, result capture and hand-off to the consumer.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   WH     | waiting for high nibble (rfd=1)
//   EH     | high nibble taken, waiting for dav_ to return high
//   WL     | waiting for low nibble (rfd=1)
//   EL     | low nibble taken, waiting for dav_ to return high
//   SETTLE | x7_x0 held stable for T_SETTLE cycles, then result captured
//   OUT    | result valid (ok=1), waiting for ack
//   EOUT   | ok dropped, waiting for ack to return low
module alimentatore_rete_totale
  import alimentatore_rete_totale_pkg::*;
#(
  parameter int T_SETTLE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dav_,
  input  logic [NIB_W-1:0]  n3_n0,
  output logic              rfd,
  output logic [BYTE_W-1:0] x7_x0,
  input  logic [RES_W-1:0]  z3_z0,
  output logic [RES_W-1:0]  ris3_ris0,
  output logic              ok,
  input  logic              ack
);

  star_t             star, star_n;
  logic              rfd_n, ok_n;
  logic [BYTE_W-1:0] x_n;
  logic [RES_W-1:0]  ris_n;
  logic              clear, enable, fine;

  contatore_attesa #(.T_SETTLE(T_SETTLE)) u_contatore_attesa (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .fine   (fine)
  );

  // State and all outputs are registered; reset discards any partial byte or result.
  always_ff @(posedge clock) begin
    if (reset) begin
      star      <= WH;
      rfd       <= 1'b1;
      ok        <= 1'b0;
      x7_x0     <= '0;
      ris3_ris0 <= '0;
    end else begin
      star      <= star_n;
      rfd       <= rfd_n;
      ok        <= ok_n;
      x7_x0     <= x_n;
      ris3_ris0 <= ris_n;
    end
  end

  // Next-state and next-output decode; registers hold unless a transition fires.
  always_comb begin
    star_n = star;
    rfd_n  = rfd;
    ok_n   = ok;
    x_n    = x7_x0;
    ris_n  = ris3_ris0;
    clear  = 1'b0;
    enable = 1'b0;
    case (star)
      WH: begin
        rfd_n = 1'b1;
        ok_n  = 1'b0;
        if (!dav_) begin
          x_n[BYTE_W-1:NIB_W] = n3_n0;
          rfd_n  = 1'b0;
          star_n = EH;
        end
      end
      EH: begin
        if (dav_) begin
          rfd_n  = 1'b1;
          star_n = WL;
        end
      end
      WL: begin
        if (!dav_) begin
          x_n[NIB_W-1:0] = n3_n0;
          rfd_n  = 1'b0;
          star_n = EL;
        end
      end
      EL: begin
        if (dav_) begin
          clear  = 1'b1;
          star_n = SETTLE;
        end
      end
      SETTLE: begin
        enable = 1'b1;
        if (fine) begin
          ris_n  = z3_z0;
          ok_n   = 1'b1;
          star_n = OUT;
        end
      end
      OUT: begin
        if (ack) begin
          ok_n   = 1'b0;
          star_n = EOUT;
        end
      end
      EOUT: begin
        if (!ack) begin
          rfd_n  = 1'b1;
          star_n = WH;
        end
      end
      default: begin
        // Unused code: recover to idle with the producer side open.
        rfd_n  = 1'b1;
        ok_n   = 1'b0;
        star_n = WH;
      end
    endcase
  end

endmodule

// File: tb/tb_alimentatore_rete_totale.sv
// Bench for alimentatore_rete_totale: table vectors, corner-case sequences
// and randomized bytes checked against a byte-level model.
module tb_alimentatore_rete_totale;

  localparam int T_A = 2;
  localparam int T_B = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dav_  = 1'b1;
  logic [3:0] n3_n0 = 4'h0;
  logic       ack   = 1'b0;
  bit         sel   = 1'b0;

  logic       rfd_a, ok_a, rfd_b, ok_b;
  logic [7:0] x_a, x_b;
  logic [3:0] ris_a, ris_b, z_a, z_b;

  logic       rfd_v, ok_v;
  logic [7:0] x_v;
  logic [3:0] ris_v;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_x;
  logic [3:0] m_ris;

  always #5 clock = ~clock;

  assign z_a = x_a[7:4] ^ x_a[3:0];
  assign z_b = x_b[7:4] ^ x_b[3:0];

  assign rfd_v = sel ? rfd_b : rfd_a;
  assign ok_v  = sel ? ok_b  : ok_a;
  assign x_v   = sel ? x_b   : x_a;
  assign ris_v = sel ? ris_b : ris_a;

  alimentatore_rete_totale #(.T_SETTLE(T_A)) dut_a (
    .clock(clock), .reset(reset), .dav_(dav_), .n3_n0(n3_n0), .rfd(rfd_a),
    .x7_x0(x_a), .z3_z0(z_a), .ris3_ris0(ris_a), .ok(ok_a), .ack(ack)
  );

  alimentatore_rete_totale #(.T_SETTLE(T_B)) dut_b (
    .clock(clock), .reset(reset), .dav_(dav_), .n3_n0(n3_n0), .rfd(rfd_b),
    .x7_x0(x_b), .z3_z0(z_b), .ris3_ris0(ris_b), .ok(ok_b), .ack(ack)
  );

  function automatic logic [3:0] net_model(input logic [7:0] b);
    return b[7:4] ^ b[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic wait_sig(input bit on_ok, input bit val, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      if ((on_ok ? ok_v : rfd_v) == val) done = 1'b1;
    end
    chk(name, on_ok ? ok_v : rfd_v, val);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    dav_  = 1'b1;
    ack   = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    m_x   = 8'h00;
    m_ris = 4'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rfd"}, rfd_v, 1);
    chk({tag, "_ok"},  ok_v,  0);
    chk({tag, "_x"},   x_v,   8'h00);
    chk({tag, "_ris"}, ris_v, 4'h0);
  endtask

  // Hand one nibble to the DUT and release dav_ after 'hold' extra low cycles.
  task automatic put_nibble(input logic [3:0] nib, input bit high, input int hold);
    wait_sig(1'b0, 1'b1, "rfd_ready");
    dav_  = 1'b0;
    n3_n0 = nib;
    wait_sig(1'b0, 1'b0, "rfd_taken");
    if (high) m_x[7:4] = nib;
    else      m_x[3:0] = nib;
    chk("x_after_nibble", x_v, m_x);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rfd_low_while_held", rfd_v, 0);
      chk("x_single_capture", x_v, m_x);
    end
    dav_  = 1'b1;
    n3_n0 = 4'($urandom);
  endtask

  // Called right after the low nibble is released: ok must appear T_SETTLE+1 edges later.
  task automatic await_result(input logic [7:0] exp_x, input logic [3:0] exp_ris);
    int t;
    int lat;
    t   = sel ? T_B : T_A;
    lat = 0;
    for (int i = 0; i < 40 && !ok_v; i++) begin
      tick();
      lat++;
    end
    chk("ok_latency", lat, t + 1);
    chk("ok_high", ok_v, 1);
    chk("rfd_low_in_out", rfd_v, 0);
    chk("x_stable", x_v, exp_x);
    m_ris = net_model(m_x);
    chk("ris_vs_model", ris_v, m_ris);
    chk("ris_vs_expected", ris_v, exp_ris);
  endtask

  task automatic consume(input int ack_dly);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("ok_held", ok_v, 1);
      chk("ris_held", ris_v, m_ris);
    end
    ack = 1'b1;
    tick();
    chk("ok_drop", ok_v, 0);
    ack = 1'b0;
    tick();
    chk("rfd_after_ack", rfd_v, 1);
    chk("ris_held_after", ris_v, m_ris);
  endtask

  // Whenever a result is offered the producer side must be closed.
  always @(negedge clock) begin
    if (ok_v) chk("rfd_low_while_ok", rfd_v, 0);
  end

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    int         hold;
    int         ack_dly;
    bit         use_b;
    logic [7:0] exp_x;
    logic [3:0] exp_ris;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit prev_sel;
    int lat;

    vecs[0] = '{hi: 4'hA, lo: 4'h5, hold: 0, ack_dly: 1, use_b: 1'b0, exp_x: 8'hA5, exp_ris: 4'hF};
    vecs[1] = '{hi: 4'h1, lo: 4'h2, hold: 5, ack_dly: 0, use_b: 1'b0, exp_x: 8'h12, exp_ris: 4'h3};
    vecs[2] = '{hi: 4'h3, lo: 4'hC, hold: 0, ack_dly: 0, use_b: 1'b1, exp_x: 8'h3C, exp_ris: 4'hF};
    vecs[3] = '{hi: 4'hF, lo: 4'hF, hold: 0, ack_dly: 0, use_b: 1'b1, exp_x: 8'hFF, exp_ris: 4'h0};
    vecs[4] = '{hi: 4'h9, lo: 4'h6, hold: 1, ack_dly: 2, use_b: 1'b0, exp_x: 8'h96, exp_ris: 4'hF};

    sel = 1'b0;
    do_reset(2);
    chk_reset_vals("reset_a");
    sel = 1'b1;
    chk_reset_vals("reset_b");
    sel = 1'b0;
    prev_sel = 1'b0;

    // Table vectors.
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].use_b != prev_sel) begin
        sel = vecs[k].use_b;
        prev_sel = sel;
        do_reset(2);
      end
      put_nibble(vecs[k].hi, 1'b1, vecs[k].hold);
      put_nibble(vecs[k].lo, 1'b0, vecs[k].hold);
      await_result(vecs[k].exp_x, vecs[k].exp_ris);
      consume(vecs[k].ack_dly);
    end

    // Stalled consumer with an eager producer.
    sel = 1'b0;
    do_reset(2);
    put_nibble(4'h4, 1'b1, 0);
    put_nibble(4'hB, 1'b0, 0);
    await_result(8'h4B, 4'hF);
    dav_  = 1'b0;
    n3_n0 = 4'h7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_ok", ok_v, 1);
      chk("stall_rfd", rfd_v, 0);
      chk("stall_ris", ris_v, 4'hF);
      chk("stall_x", x_v, 8'h4B);
    end
    ack = 1'b1;
    tick();
    chk("stall_eout_ok", ok_v, 0);
    chk("stall_eout_rfd", rfd_v, 0);
    ack = 1'b0;
    tick();
    chk("stall_wh_rfd", rfd_v, 1);
    tick();
    m_x[7:4] = 4'h7;
    chk("stall_accept_rfd", rfd_v, 0);
    chk("stall_accept_x", x_v, 8'h7B);
    dav_ = 1'b1;
    put_nibble(4'h1, 1'b0, 0);
    await_result(8'h71, 4'h6);
    consume(0);

    // Reset while settling.
    put_nibble(4'h5, 1'b1, 0);
    put_nibble(4'h3, 1'b0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_settle");
    reset = 1'b0;
    m_x = 8'h00;
    m_ris = 4'h0;
    tick();
    chk("rst_settle_no_ok", ok_v, 0);
    put_nibble(4'h9, 1'b1, 0);
    put_nibble(4'h6, 1'b0, 0);
    await_result(8'h96, 4'hF);

    // Reset while the result is offered.
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_out");
    reset = 1'b0;
    m_x = 8'h00;
    m_ris = 4'h0;
    put_nibble(4'h9, 1'b1, 0);
    put_nibble(4'h6, 1'b0, 0);
    await_result(8'h96, 4'hF);
    consume(0);

    // Early ack: already high before OUT.
    put_nibble(4'h2, 1'b1, 0);
    put_nibble(4'hE, 1'b0, 0);
    ack = 1'b1;
    lat = 0;
    for (int i = 0; i < 40 && !ok_v; i++) begin
      tick();
      lat++;
    end
    chk("early_latency", lat, T_A + 1);
    chk("early_ris", ris_v, 4'hC);
    tick();
    chk("early_ok_one_cycle", ok_v, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("early_wait_eout_rfd", rfd_v, 0);
      chk("early_wait_eout_ok", ok_v, 0);
    end
    ack = 1'b0;
    tick();
    chk("early_rfd_back", rfd_v, 1);
    m_x = 8'h2E;
    m_ris = 4'hC;

    // Randomized bytes against the byte-level model, alternating settle times.
    for (int r = 0; r < 16; r++) begin
      logic [3:0] hi, lo;
      int hold, ack_dly;
      hi = 4'($urandom);
      lo = 4'($urandom);
      hold = int'($urandom_range(0, 3));
      ack_dly = int'($urandom_range(0, 3));
      if ((r % 8) == 0) begin
        sel = (r >= 8);
        do_reset(1 + int'($urandom_range(0, 2)));
      end
      put_nibble(hi, 1'b1, hold);
      put_nibble(lo, 1'b0, hold);
      await_result({hi, lo}, net_model({hi, lo}));
      consume(ack_dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
